// File: rtl/cla_pkg.sv
// Shared types and constants for the multi-word carry-lookahead add/sub sequencer.
package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } cla_seq_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : cla_pkg

// File: rtl/cla_multiword_seq_if.sv
// Request/result handshake bundle between the producer, the sequencer and the consumer.
interface cla_multiword_seq_if #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) ();

    localparam int TOTAL = WIDTH * WORDS;

    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [TOTAL-1:0] in_a;
    logic [TOTAL-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [TOTAL-1:0] out_sum;
    logic             out_carry;

    // Producer/consumer side of the bundle.
    modport master (
        output in_valid, in_sub, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );

    // Sequencer side of the bundle.
    modport slave (
        input  in_valid, in_sub, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );

endinterface : cla_multiword_seq_if

// File: rtl/cla_slice.sv
// Combinational WIDTH-bit carry-lookahead adder; every internal carry is a flat
// sum-of-products over generate/propagate terms and the carry-in.
module cla_slice #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        logic term_c;
        logic term_p;
        // NOTE: every variable written in a combinational block gets a value
        // before any branch or loop, otherwise synthesis infers a latch.
        carry    = '0;
        term_c   = 1'b0;
        term_p   = 1'b0;
        carry[0] = cin;
        // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded rather than rippled.
        for (int i = 0; i < WIDTH; i++) begin
            term_c = gen[i];
            term_p = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                term_c = term_c | (term_p & gen[j]);
                term_p = term_p & prop[j];
            end
            carry[i+1] = term_c | (term_p & cin);
        end
    end

    assign sum  = prop ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule : cla_slice

// File: rtl/cla_multiword_seq.sv
// Adds or subtracts WORDS*WIDTH-bit operands one WIDTH-bit word per cycle, LSW first,
// reusing a single lookahead slice and carrying between words through a register.
module cla_multiword_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    cla_multiword_seq_if.slave  bus
);

    localparam int TOTAL = WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    cla_seq_state_t   state_q, state_d;
    logic [TOTAL-1:0] a_q, a_d;
    logic [TOTAL-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [TOTAL-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             in_ready;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_cout;

    assign in_ready = (state_q == ST_IDLE);

    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
    assign a_word = a_q[int'(idx_q)*WIDTH +: WIDTH];
    assign b_word = b_q[int'(idx_q)*WIDTH +: WIDTH] ^ {WIDTH{sub_q == OP_SUB}};

    cla_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    sub_d   = bus.in_sub;
                    carry_d = (bus.in_sub == OP_ADD) ? 1'b0 : 1'b1;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[int'(idx_q)*WIDTH +: WIDTH] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = slice_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            // NOTE: registers update with non-blocking assignments so every flop
            // samples the pre-edge value of the others, independent of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_carry = cout_q;

endmodule : cla_multiword_seq

// File: tb/tb_cla_multiword_seq.sv
// Directed bench for cla_multiword_seq at WIDTH=4, WORDS=4 with hand-computed results.
module tb_cla_multiword_seq;

    logic clk;
    logic rst;
    int   tests_run = 0;
    int   fails     = 0;
    int   cyc       = 0;

    cla_multiword_seq_if #(.WIDTH(4), .WORDS(4)) bus ();

    cla_multiword_seq #(
        .WIDTH (4),
        .WORDS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until out_valid, bounded; returns edges elapsed since the call.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] exp_sum, input logic exp_c);
        int lat;
        wait_ready();
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(bus.out_sum), 32'(exp_sum));
        check({tag, "_carry"}, 32'(bus.out_carry), 32'(exp_c));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_vdrop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc_cyc[3];
        logic [15:0] v_a[3];
        logic [15:0] v_b[3];
        logic        v_sub[3];
        logic [15:0] v_sum[3];
        logic        v_c[3];

        v_a[0] = 16'hABCD; v_b[0] = 16'h1111; v_sub[0] = 1'b0; v_sum[0] = 16'hBCDE; v_c[0] = 1'b0;
        v_a[1] = 16'h0005; v_b[1] = 16'h0007; v_sub[1] = 1'b1; v_sum[1] = 16'hFFFE; v_c[1] = 1'b0;
        v_a[2] = 16'hF000; v_b[2] = 16'h1000; v_sub[2] = 1'b0; v_sum[2] = 16'h0000; v_c[2] = 1'b1;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sub    = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.out_sum), 32'd0);
        check("rst_carry", 32'(bus.out_carry), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: full carry propagation across every word
        do_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

        // 2: subtraction with and without borrow
        do_op("sub_nob", 16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1);
        do_op("sub_bor", 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0);

        // 3: backpressure in DONE with a pending request held on the input
        wait_ready();
        bus.in_a = 16'h0102; bus.in_b = 16'h0304; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_a = 16'h1111; bus.in_b = 16'h2222;
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_sum", 32'(bus.out_sum), 32'h0406);
            check("bp_carry", 32'(bus.out_carry), 32'd0);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_vdrop", 32'(bus.out_valid), 32'd0);
        check("bp_idle", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_accept2", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("bp2_lat", 32'(lat), 32'd4);
        check("bp2_sum", 32'(bus.out_sum), 32'h3333);
        check("bp2_carry", 32'(bus.out_carry), 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // 4: operand inputs scrambled while the operation runs
        wait_ready();
        bus.in_a = 16'h00F0; bus.in_b = 16'h0F10; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            bus.in_a   = 16'($urandom);
            bus.in_b   = 16'($urandom);
            bus.in_sub = 1'($urandom);
            step();
            lat++;
        end
        bus.in_sub = 1'b0;
        check("scr_lat", 32'(lat), 32'd4);
        check("scr_sum", 32'(bus.out_sum), 32'h1000);
        check("scr_carry", 32'(bus.out_carry), 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // 5: reset on the second RUN cycle aborts the operation
        wait_ready();
        bus.in_a = 16'h1234; bus.in_b = 16'h1111;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_sum", 32'(bus.out_sum), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step();
        do_op("post_rst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // 6: back-to-back with in_valid and out_ready held high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_a   = v_a[i];
            bus.in_b   = v_b[i];
            bus.in_sub = v_sub[i];
            wait_ready();
            step();
            acc_cyc[i] = cyc;
            if (i > 0) check("b2b_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);
            wait_valid(lat);
            check("b2b_lat", 32'(lat), 32'd4);
            check("b2b_sum", 32'(bus.out_sum), 32'(v_sum[i]));
            check("b2b_carry", 32'(bus.out_carry), 32'(v_c[i]));
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        check("b2b_end_idle", 32'(bus.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_cla_multiword_seq
